// File: rtl/pipeline_register.sv
// pipeline_register: elastic DEPTH-stage register slice with valid/ready
// handshake, bubble collapsing, synchronous flush and occupancy count.
module pipeline_register #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 2
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         FLUSH,
   input  logic [WIDTH-1:0]             in_data,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] data_q [DEPTH];
   logic [DEPTH-1:0] valid_q;
   logic [OCC_W-1:0] occ_q;

   // rdy[i]: stage i may load this cycle; rdy[DEPTH] is the consumer side
   logic [DEPTH:0]   rdy;
   logic             in_xfer;
   logic             out_xfer;

   // Backward ready chain: an empty stage always accepts, a full one only if it drains
   always_comb begin
      rdy        = '0;
      rdy[DEPTH] = out_ready & ~FLUSH;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         rdy[i] = ~valid_q[i] | rdy[i+1];
      end
      in_ready  = rdy[0] & ~FLUSH & ~RST;
      out_valid = valid_q[DEPTH-1] & ~FLUSH & ~RST;
      out_data  = data_q[DEPTH-1];
      in_xfer   = in_valid & in_ready;
      out_xfer  = out_valid & out_ready;
   end

   // Stage registers: each stage loads from its upstream neighbour when ready, else holds
   always_ff @(posedge CLK) begin
      if (RST) begin
         valid_q <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            data_q[i] <= '0;
         end
      end else if (FLUSH) begin
         valid_q <= '0;
      end else begin
         if (rdy[0]) begin
            valid_q[0] <= in_valid;
            data_q[0]  <= in_data;
         end
         for (int i = 1; i < int'(DEPTH); i++) begin
            if (rdy[i]) begin
               valid_q[i] <= valid_q[i-1];
               data_q[i]  <= data_q[i-1];
            end
         end
      end
   end

   // Occupancy tracks accepted-minus-delivered entries
   always_ff @(posedge CLK) begin
      if (RST || FLUSH) begin
         occ_q <= '0;
      end else begin
         case ({in_xfer, out_xfer})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_pipeline_register.sv
// tb_pipeline_register: randomized checks of pipeline_register against a
// queue-based timing model (entry visible at max(accept+DEPTH, prev_departure+1)).
module tb_pipeline_register;

   logic        CLK;
   logic        RST;
   logic        FLUSH;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_data;

   logic        ir2, ov2, ir4, ov4, ir3, ov3, ir1, ov1;
   logic [15:0] od2, od4, od3;
   logic [31:0] od1;
   logic [1:0]  occ2, occ3;
   logic [2:0]  occ4;
   logic [0:0]  occ1;

   int          n_checks = 0;
   int          n_fail = 0;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   pipeline_register #(.WIDTH(16), .DEPTH(2)) u_d2 (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .in_data(in_data[15:0]), .in_valid(in_valid),
      .in_ready(ir2), .out_data(od2), .out_valid(ov2), .out_ready(out_ready), .occupancy(occ2));
   pipeline_register #(.WIDTH(16), .DEPTH(4)) u_d4 (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .in_data(in_data[15:0]), .in_valid(in_valid),
      .in_ready(ir4), .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .occupancy(occ4));
   pipeline_register #(.WIDTH(16), .DEPTH(3)) u_d3 (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .in_data(in_data[15:0]), .in_valid(in_valid),
      .in_ready(ir3), .out_data(od3), .out_valid(ov3), .out_ready(out_ready), .occupancy(occ3));
   pipeline_register #(.WIDTH(32), .DEPTH(1)) u_d1 (
      .CLK(CLK), .RST(RST), .FLUSH(FLUSH), .in_data(in_data), .in_valid(in_valid),
      .in_ready(ir1), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .occupancy(occ1));

   // Selected DUT under check
   int          sel;
   logic        cur_ir, cur_ov;
   logic [31:0] cur_od, cur_occ;

   always_comb begin
      case (sel)
         0:       begin cur_ir = ir2; cur_ov = ov2; cur_od = 32'(od2); cur_occ = 32'(occ2); end
         1:       begin cur_ir = ir4; cur_ov = ov4; cur_od = 32'(od4); cur_occ = 32'(occ4); end
         2:       begin cur_ir = ir3; cur_ov = ov3; cur_od = 32'(od3); cur_occ = 32'(occ3); end
         default: begin cur_ir = ir1; cur_ov = ov1; cur_od = od1;      cur_occ = 32'(occ1); end
      endcase
   end

   // Reference model: FIFO of accepted entries with acceptance cycle
   typedef struct {
      logic [31:0] d;
      int          acc;
   } ent_t;

   ent_t        q[$];
   int          last_dep;
   int          n;
   int          depth;
   logic [31:0] mask;
   logic        e_ov, e_ir;
   logic [31:0] e_od;
   int          e_occ;

   task automatic select_dut(input int s);
      sel = s;
      case (s)
         0:       begin depth = 2; mask = 32'h0000_FFFF; end
         1:       begin depth = 4; mask = 32'h0000_FFFF; end
         2:       begin depth = 3; mask = 32'h0000_FFFF; end
         default: begin depth = 1; mask = 32'hFFFF_FFFF; end
      endcase
   endtask

   task automatic model_expect();
      int vis;
      e_occ = q.size();
      e_ov  = 1'b0;
      e_od  = '0;
      if (q.size() > 0) begin
         vis = q[0].acc + depth;
         if (last_dep + 1 > vis) vis = last_dep + 1;
         e_ov = (vis <= n) && !RST && !FLUSH;
         e_od = q[0].d;
      end
      e_ir = !RST && !FLUSH && ((q.size() < depth) || out_ready);
   endtask

   task automatic model_commit();
      ent_t e;
      if (RST || FLUSH) begin
         q.delete();
      end else begin
         if (e_ov && out_ready) begin
            void'(q.pop_front());
            last_dep = n;
         end
         if (in_valid && e_ir) begin
            e.d   = in_data & mask;
            e.acc = n;
            q.push_back(e);
         end
      end
      n++;
   endtask

   task automatic sample();
      @(negedge CLK);
      model_expect();
   endtask

   task automatic advance();
      @(posedge CLK);
      model_commit();
      #1;
   endtask

   task automatic apply_reset();
      RST = 1'b1; FLUSH = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
      repeat (2) @(posedge CLK);
      #1;
      RST = 1'b0;
      q.delete();
      n = 0;
      last_dep = -100;
   endtask

   task automatic test_reset();
      select_dut(0);
      RST = 1'b1; FLUSH = 1'b0; in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h0000_BEEF;
      @(posedge CLK);
      #1;
      repeat (2) begin
         @(negedge CLK);
         n_checks++;
         if (cur_ir !== 1'b0) begin n_fail++; $display("FAIL reset in_ready got %b exp 0", cur_ir); end
         n_checks++;
         if (cur_ov !== 1'b0) begin n_fail++; $display("FAIL reset out_valid got %b exp 0", cur_ov); end
         n_checks++;
         if (cur_od !== 32'h0) begin n_fail++; $display("FAIL reset out_data got %h exp 0", cur_od); end
         n_checks++;
         if (cur_occ !== 32'h0) begin n_fail++; $display("FAIL reset occupancy got %0d exp 0", cur_occ); end
         @(posedge CLK);
         #1;
      end
      RST = 1'b0; in_valid = 1'b0;
      @(negedge CLK);
      n_checks++;
      if (cur_ir !== 1'b1) begin n_fail++; $display("FAIL reset_release in_ready got %b exp 1", cur_ir); end
      n_checks++;
      if (cur_ov !== 1'b0) begin n_fail++; $display("FAIL reset_release out_valid got %b exp 0", cur_ov); end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_streaming();
      int got;
      got = 0;
      apply_reset();
      select_dut(0);
      for (int i = 0; i < 20; i++) begin
         in_valid = (i < 16); in_data = 32'(i + 1); out_ready = 1'b1;
         sample();
         if (cur_ov && out_ready) got++;
         n_checks++;
         if (cur_ov !== e_ov) begin n_fail++; $display("FAIL stream out_valid n=%0d got %b exp %b", n, cur_ov, e_ov); end
         n_checks++;
         if (cur_ir !== e_ir) begin n_fail++; $display("FAIL stream in_ready n=%0d got %b exp %b", n, cur_ir, e_ir); end
         n_checks++;
         if (cur_occ !== 32'(e_occ)) begin n_fail++; $display("FAIL stream occupancy n=%0d got %0d exp %0d", n, cur_occ, e_occ); end
         if (e_ov) begin
            n_checks++;
            if (cur_od !== e_od) begin n_fail++; $display("FAIL stream out_data n=%0d got %h exp %h", n, cur_od, e_od); end
         end
         advance();
      end
      n_checks++;
      if (got !== 16) begin n_fail++; $display("FAIL stream word_count got %0d exp 16", got); end
   endtask

   task automatic test_backpressure();
      apply_reset();
      select_dut(1);
      for (int i = 0; i < 226; i++) begin
         if (i < 6) begin
            in_valid = 1'b1; in_data = 32'h0000_A000 + 32'(i); out_ready = 1'b0;
         end else if (i < 16) begin
            in_valid = (i == 6); in_data = 32'h0000_A000 + 32'(i); out_ready = (i > 6);
         end else begin
            in_valid = 1'($urandom_range(0, 1)); in_data = $urandom & mask;
            out_ready = ($urandom_range(0, 3) != 0);
         end
         sample();
         if (i == 6) begin
            n_checks++;
            if (cur_occ !== 32'd4) begin n_fail++; $display("FAIL bp_full occupancy got %0d exp 4", cur_occ); end
            n_checks++;
            if (cur_od !== 32'h0000_A000) begin n_fail++; $display("FAIL bp_full out_data got %h exp a000", cur_od); end
            n_checks++;
            if (cur_ir !== 1'b0) begin n_fail++; $display("FAIL bp_full in_ready got %b exp 0", cur_ir); end
         end
         n_checks++;
         if (cur_ov !== e_ov) begin n_fail++; $display("FAIL bp out_valid n=%0d got %b exp %b", n, cur_ov, e_ov); end
         n_checks++;
         if (cur_ir !== e_ir) begin n_fail++; $display("FAIL bp in_ready n=%0d got %b exp %b", n, cur_ir, e_ir); end
         n_checks++;
         if (cur_occ !== 32'(e_occ)) begin n_fail++; $display("FAIL bp occupancy n=%0d got %0d exp %0d", n, cur_occ, e_occ); end
         if (e_ov) begin
            n_checks++;
            if (cur_od !== e_od) begin n_fail++; $display("FAIL bp out_data n=%0d got %h exp %h", n, cur_od, e_od); end
         end
         advance();
      end
   endtask

   task automatic test_bubble();
      logic [6:0] vpat;
      vpat = 7'b0001001;
      apply_reset();
      select_dut(1);
      for (int i = 0; i < 10; i++) begin
         in_valid  = (i < 7) ? vpat[i] : 1'b0;
         in_data   = (i == 0) ? 32'h0000_1111 : 32'h0000_2222;
         out_ready = (i == 8);
         sample();
         if (i == 7) begin
            n_checks++;
            if (cur_ov !== 1'b1 || cur_od !== 32'h0000_1111) begin
               n_fail++; $display("FAIL bubble head got v=%b d=%h exp v=1 d=1111", cur_ov, cur_od);
            end
            n_checks++;
            if (cur_occ !== 32'd2) begin n_fail++; $display("FAIL bubble occupancy got %0d exp 2", cur_occ); end
            n_checks++;
            if (cur_ir !== 1'b1) begin n_fail++; $display("FAIL bubble in_ready got %b exp 1", cur_ir); end
         end
         if (i == 9) begin
            n_checks++;
            if (cur_ov !== 1'b1 || cur_od !== 32'h0000_2222) begin
               n_fail++; $display("FAIL bubble second got v=%b d=%h exp v=1 d=2222", cur_ov, cur_od);
            end
         end
         n_checks++;
         if (cur_ov !== e_ov) begin n_fail++; $display("FAIL bubble out_valid n=%0d got %b exp %b", n, cur_ov, e_ov); end
         n_checks++;
         if (cur_occ !== 32'(e_occ)) begin n_fail++; $display("FAIL bubble occupancy n=%0d got %0d exp %0d", n, cur_occ, e_occ); end
         advance();
      end
   endtask

   task automatic test_flush();
      apply_reset();
      select_dut(2);
      for (int i = 0; i < 130; i++) begin
         FLUSH = 1'b0; RST = 1'b0;
         if (i < 3) begin
            in_valid = 1'b1; in_data = $urandom & mask; out_ready = 1'b0;
         end else if (i == 3) begin
            FLUSH = 1'b1; in_valid = 1'b1; in_data = 32'h0000_DEAD; out_ready = 1'b1;
         end else if (i == 4) begin
            in_valid = 1'b1; in_data = 32'h0000_5A5A; out_ready = 1'b1;
         end else if (i < 12) begin
            in_valid = 1'b0; out_ready = 1'b1;
         end else begin
            in_valid = 1'($urandom_range(0, 1)); in_data = $urandom & mask;
            out_ready = 1'($urandom_range(0, 1));
            FLUSH = ($urandom_range(0, 15) == 0);
            RST   = ($urandom_range(0, 31) == 0);
         end
         sample();
         if (i == 3) begin
            n_checks++;
            if (cur_occ !== 32'd3) begin n_fail++; $display("FAIL flush pre occupancy got %0d exp 3", cur_occ); end
            n_checks++;
            if (cur_ov !== 1'b0 || cur_ir !== 1'b0) begin
               n_fail++; $display("FAIL flush gating got ov=%b ir=%b exp 0 0", cur_ov, cur_ir);
            end
         end
         if (i == 4) begin
            n_checks++;
            if (cur_occ !== 32'd0 || cur_ov !== 1'b0 || cur_ir !== 1'b1) begin
               n_fail++; $display("FAIL flush after got occ=%0d ov=%b ir=%b exp 0 0 1", cur_occ, cur_ov, cur_ir);
            end
         end
         if (i == 7) begin
            n_checks++;
            if (cur_ov !== 1'b1 || cur_od !== 32'h0000_5A5A) begin
               n_fail++; $display("FAIL flush new_word got v=%b d=%h exp v=1 d=5a5a", cur_ov, cur_od);
            end
         end
         n_checks++;
         if (cur_ov !== e_ov) begin n_fail++; $display("FAIL flush out_valid n=%0d got %b exp %b", n, cur_ov, e_ov); end
         n_checks++;
         if (cur_ir !== e_ir) begin n_fail++; $display("FAIL flush in_ready n=%0d got %b exp %b", n, cur_ir, e_ir); end
         n_checks++;
         if (cur_occ !== 32'(e_occ)) begin n_fail++; $display("FAIL flush occupancy n=%0d got %0d exp %0d", n, cur_occ, e_occ); end
         if (e_ov) begin
            n_checks++;
            if (cur_od !== e_od) begin n_fail++; $display("FAIL flush out_data n=%0d got %h exp %h", n, cur_od, e_od); end
         end
         advance();
      end
      FLUSH = 1'b0; RST = 1'b0;
   endtask

   task automatic test_depth1();
      apply_reset();
      select_dut(3);
      for (int i = 0; i < 160; i++) begin
         in_data = $urandom;
         if (i < 60) begin
            in_valid = 1'b1; out_ready = (i % 2 == 1);
         end else begin
            in_valid = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1));
         end
         sample();
         if (i >= 1 && i < 60) begin
            n_checks++;
            if (cur_occ !== 32'd1) begin n_fail++; $display("FAIL d1 steady occupancy n=%0d got %0d exp 1", n, cur_occ); end
         end
         n_checks++;
         if (cur_ov !== e_ov) begin n_fail++; $display("FAIL d1 out_valid n=%0d got %b exp %b", n, cur_ov, e_ov); end
         n_checks++;
         if (cur_ir !== e_ir) begin n_fail++; $display("FAIL d1 in_ready n=%0d got %b exp %b", n, cur_ir, e_ir); end
         n_checks++;
         if (cur_occ !== 32'(e_occ)) begin n_fail++; $display("FAIL d1 occupancy n=%0d got %0d exp %0d", n, cur_occ, e_occ); end
         if (e_ov) begin
            n_checks++;
            if (cur_od !== e_od) begin n_fail++; $display("FAIL d1 out_data n=%0d got %h exp %h", n, cur_od, e_od); end
         end
         advance();
      end
   endtask

   initial begin
      sel = 0; depth = 2; mask = 32'h0000_FFFF; n = 0; last_dep = -100;
      test_reset();
      test_streaming();
      test_backpressure();
      test_bubble();
      test_flush();
      test_depth1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
